// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive input-vector sequencer with MISR response capture.
// Walks every N_IN-bit vector up or down and holds each one for DWELL cycles.
// It samples the circuit under test SETTLE cycles into each dwell and folds
// every sample into a 16-bit signature.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 5,
    parameter int DWELL  = 100,
    parameter int SETTLE = 2,
    parameter int SIG_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             descending,
    input  logic             loop,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             sample_valid,
    output logic [N_IN-1:0]  sample_vec,
    output logic [N_OUT-1:0] sample_data,
    output logic [SIG_W-1:0] signature,
    output logic [7:0]       wrap_cnt,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  VEC_ONES   = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [N_IN-1:0]  r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_desc;
    logic             r_loop;
    logic             r_sample_valid;
    logic [N_IN-1:0]  r_sample_vec;
    logic [N_OUT-1:0] r_sample_data;
    logic [SIG_W-1:0] r_sig;
    logic [7:0]       r_wrap;

    logic             w_start_ok;
    logic             w_drive_ok;
    logic             w_sample;
    logic             w_dwell_end;
    logic             w_last_vec;
    logic [SIG_W-1:0] w_resp_ext;
    logic [SIG_W-1:0] w_sig_next;

    // An abort in DRIVE wins over everything, so sampling and stepping are
    // gated on it; start is honoured only from IDLE and only without abort.
    assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
    assign w_drive_ok  = (r_state == S_DRIVE) && !abort;
    assign w_sample    = w_drive_ok && (r_cnt == CNT_SETTLE);
    assign w_dwell_end = w_drive_ok && (r_cnt == CNT_LAST);
    assign w_last_vec  = r_desc ? (r_vec == '0) : (r_vec == VEC_ONES);

    // Zero-extend the response to signature width and compute the MISR step.
    always_comb begin
        w_resp_ext = '0;
        w_resp_ext[N_OUT-1:0] = dut_out;
        w_sig_next = {r_sig[14:0], r_sig[15] ^ r_sig[14] ^ r_sig[12] ^ r_sig[3]} ^ w_resp_ext;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: DONE lasts exactly one cycle, looping sweeps never reach it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_dwell_end && w_last_vec && !r_loop) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector stepping, dwell counting, sampling and signature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec          <= '0;
            r_cnt          <= '0;
            r_desc         <= 1'b0;
            r_loop         <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_vec   <= '0;
            r_sample_data  <= '0;
            r_sig          <= '0;
            r_wrap         <= '0;
        end else begin
            r_sample_valid <= w_sample;
            if (w_start_ok) begin
                r_desc <= descending;
                r_loop <= loop;
                r_vec  <= descending ? VEC_ONES : '0;
                r_cnt  <= '0;
                r_sig  <= '0;
                r_wrap <= '0;
            end else if (w_drive_ok) begin
                if (w_sample) begin
                    r_sample_data <= dut_out;
                    r_sample_vec  <= r_vec;
                    r_sig         <= w_sig_next;
                end
                if (w_dwell_end) begin
                    r_cnt <= '0;
                    if (!w_last_vec) begin
                        r_vec <= r_desc ? (r_vec - N_IN'(1)) : (r_vec + N_IN'(1));
                    end else if (r_loop) begin
                        r_vec <= r_desc ? VEC_ONES : '0;
                        if (r_wrap != 8'hFF) begin
                            r_wrap <= r_wrap + 8'd1;
                        end
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign dut_in       = r_vec;
    assign sample_valid = r_sample_valid;
    assign sample_vec   = r_sample_vec;
    assign sample_data  = r_sample_data;
    assign signature    = r_sig;
    assign wrap_cnt     = r_wrap;
    assign busy         = (r_state == S_DRIVE);
    assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for the truth-table sweeper.
// Instance A uses N_IN=3, DWELL=4, SETTLE=2. Instance B uses N_IN=1, DWELL=2,
// SETTLE=1, so sampling and vector advance fall on the same edge.
// Both instances feed a stub circuit that echoes dut_in zero-extended.
module tb_truth_table_sweeper;

    typedef struct {
        logic [2:0]  vec;
        logic [4:0]  data;
        logic [15:0] sig;
    } sample_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        descending;
    logic        loop;
    logic        abort;
    logic        startB;
    logic        abortB;

    logic [2:0]  dutInA;
    logic [4:0]  dutOutA;
    logic        sampleValidA;
    logic [2:0]  sampleVecA;
    logic [4:0]  sampleDataA;
    logic [15:0] signatureA;
    logic [7:0]  wrapCntA;
    logic        busyA;
    logic        doneA;

    logic [0:0]  dutInB;
    logic [4:0]  dutOutB;
    logic        sampleValidB;
    logic [0:0]  sampleVecB;
    logic [4:0]  sampleDataB;
    logic [15:0] signatureB;
    logic [7:0]  wrapCntB;
    logic        busyB;
    logic        doneB;

    int          checks;
    int          failures;
    sample_t     expA[$];
    sample_t     expB[$];
    logic [15:0] modelSigA;
    logic [15:0] modelSigB;
    logic [15:0] ascSig;

    // Stub circuits under test: each simply echoes its vector on the low bits.
    assign dutOutA = {2'b00, dutInA};
    assign dutOutB = {4'b0000, dutInB};

    truth_table_sweeper #(
        .N_IN(3), .N_OUT(5), .DWELL(4), .SETTLE(2), .SIG_W(16)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .descending(descending),
        .loop(loop), .abort(abort), .dut_in(dutInA), .dut_out(dutOutA),
        .sample_valid(sampleValidA), .sample_vec(sampleVecA),
        .sample_data(sampleDataA), .signature(signatureA),
        .wrap_cnt(wrapCntA), .busy(busyA), .done(doneA)
    );

    truth_table_sweeper #(
        .N_IN(1), .N_OUT(5), .DWELL(2), .SETTLE(1), .SIG_W(16)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .descending(1'b0),
        .loop(1'b0), .abort(abortB), .dut_in(dutInB), .dut_out(dutOutB),
        .sample_valid(sampleValidB), .sample_vec(sampleVecB),
        .sample_data(sampleDataB), .signature(signatureB),
        .wrap_cnt(wrapCntB), .busy(busyB), .done(doneB)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report it if actual and expected differ.
    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference MISR step, written straight from the signature polynomial.
    function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] d);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {11'b0, d};
    endfunction

    // Queue the sample instance A should produce for a vector, advancing its model signature.
    task pushA(input logic [2:0] v);
        sample_t e;
        e.vec     = v;
        e.data    = {2'b00, v};
        modelSigA = misr(modelSigA, e.data);
        e.sig     = modelSigA;
        expA.push_back(e);
    endtask

    // Same as pushA, for the single-bit instance B.
    task pushB(input logic [0:0] v);
        sample_t e;
        e.vec     = {2'b00, v};
        e.data    = {4'b0000, v};
        modelSigB = misr(modelSigB, e.data);
        e.sig     = modelSigB;
        expB.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the control inputs of instance A.
    task applyStimulus(input logic s, input logic d, input logic l, input logic a);
        start      = s;
        descending = d;
        loop       = l;
        abort      = a;
    endtask

    // Monitor A: on every strobe, pop the oldest expectation and compare all fields.
    task monitorA();
        sample_t e;
        forever begin
            @(negedge clk);
            if (sampleValidA) begin
                checkOutput("A sample expected", 32'(expA.size() > 0), 32'(1));
                if (expA.size() > 0) begin
                    e = expA.pop_front();
                    checkOutput("A sample_vec", 32'(sampleVecA), 32'(e.vec));
                    checkOutput("A sample_data", 32'(sampleDataA), 32'(e.data));
                    checkOutput("A signature", 32'(signatureA), 32'(e.sig));
                end
            end
        end
    endtask

    // Monitor B: same scoreboard check for the single-bit instance.
    task monitorB();
        sample_t e;
        forever begin
            @(negedge clk);
            if (sampleValidB) begin
                checkOutput("B sample expected", 32'(expB.size() > 0), 32'(1));
                if (expB.size() > 0) begin
                    e = expB.pop_front();
                    checkOutput("B sample_vec", 32'({2'b00, sampleVecB}), 32'(e.vec));
                    checkOutput("B sample_data", 32'(sampleDataB), 32'(e.data));
                    checkOutput("B signature", 32'(signatureB), 32'(e.sig));
                end
            end
        end
    endtask

    // Full non-looping sweep on instance A. The direction input is flipped
    // right after start to confirm it is latched rather than followed.
    task sweepA(input logic desc);
        logic [2:0] v;
        modelSigA = '0;
        for (int i = 0; i < 8; i++) begin
            pushA(desc ? 3'(7 - i) : 3'(i));
        end
        applyStimulus(1'b1, desc, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, ~desc, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            v = desc ? 3'(7 - k / 4) : 3'(k / 4);
            checkOutput("A dut_in during sweep", 32'(dutInA), 32'(v));
            checkOutput("A busy during sweep", 32'(busyA), 32'(1));
            tick();
        end
        checkOutput("A done at sweep end", 32'(doneA), 32'(1));
        checkOutput("A busy at sweep end", 32'(busyA), 32'(0));
        checkOutput("A dut_in holds last", 32'(dutInA), desc ? 32'(0) : 32'(7));
        checkOutput("A all samples seen", 32'(expA.size()), 32'(0));
        checkOutput("A final signature", 32'(signatureA), 32'(modelSigA));
        tick();
        checkOutput("A done one cycle", 32'(doneA), 32'(0));
        checkOutput("A busy after done", 32'(busyA), 32'(0));
    endtask

    // Main sequence: reset, the six scenarios, then the summary.
    initial begin
        checks    = 0;
        failures  = 0;
        modelSigA = '0;
        modelSigB = '0;
        ascSig    = '0;
        rst_n     = 1'b0;
        startB    = 1'b0;
        abortB    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        fork
            monitorA();
            monitorB();
        join_none

        // Reset state.
        tick();
        tick();
        checkOutput("reset dut_in", 32'(dutInA), 32'(0));
        checkOutput("reset busy", 32'(busyA), 32'(0));
        checkOutput("reset done", 32'(doneA), 32'(0));
        checkOutput("reset signature", 32'(signatureA), 32'(0));
        checkOutput("reset sample_valid", 32'(sampleValidA), 32'(0));
        rst_n = 1'b1;
        tick();

        // 1. Ascending sweep.
        $display("[TB] test 1: ascending sweep");
        sweepA(1'b0);
        ascSig = modelSigA;

        // 2. Descending sweep; its signature must differ from the ascending one.
        $display("[TB] test 2: descending sweep");
        sweepA(1'b1);
        checkOutput("A desc sig differs from asc", 32'(signatureA != ascSig), 32'(1));

        // 3. Looping sweep: three full passes, then abort.
        $display("[TB] test 3: loop and abort");
        modelSigA = '0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                pushA(3'(i));
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 96; k++) begin
            if (k == 31) checkOutput("A loop last vec", 32'(dutInA), 32'(7));
            if (k == 32) checkOutput("A loop wraps to 0", 32'(dutInA), 32'(0));
            if (k == 32) checkOutput("A wrap_cnt 1", 32'(wrapCntA), 32'(1));
            if (k == 63) checkOutput("A wrap_cnt before 2", 32'(wrapCntA), 32'(1));
            if (k == 64) checkOutput("A wrap_cnt 2", 32'(wrapCntA), 32'(2));
            if (k == 95) checkOutput("A wrap_cnt before 3", 32'(wrapCntA), 32'(2));
            if (k == 96) checkOutput("A wrap_cnt 3", 32'(wrapCntA), 32'(3));
            checkOutput("A loop no done", 32'(doneA), 32'(0));
            if (k < 96) tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A busy after abort", 32'(busyA), 32'(0));
        checkOutput("A wrap_cnt holds", 32'(wrapCntA), 32'(3));
        checkOutput("A loop samples seen", 32'(expA.size()), 32'(0));
        checkOutput("A loop signature", 32'(signatureA), 32'(modelSigA));
        for (int k = 0; k < 3; k++) begin
            checkOutput("A abort no done", 32'(doneA), 32'(0));
            tick();
        end

        // 4. Abort on a sampling edge, then start+abort together in IDLE.
        $display("[TB] test 4: abort on sample edge");
        modelSigA = '0;
        pushA(3'd7);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A abort busy", 32'(busyA), 32'(0));
        checkOutput("A abort done", 32'(doneA), 32'(0));
        checkOutput("A abort sig holds", 32'(signatureA), 32'(modelSigA));
        checkOutput("A abort sample_vec holds", 32'(sampleVecA), 32'(7));
        checkOutput("A abort sample_data holds", 32'(sampleDataA), 32'(7));
        checkOutput("A abort dut_in holds", 32'(dutInA), 32'(6));
        checkOutput("A abort samples seen", 32'(expA.size()), 32'(0));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A start+abort stays idle", 32'(busyA), 32'(0));
        checkOutput("A start+abort sig holds", 32'(signatureA), 32'(modelSigA));
        checkOutput("A start+abort dut_in", 32'(dutInA), 32'(6));
        tick();
        checkOutput("A start+abort still idle", 32'(busyA), 32'(0));

        // 5. Asynchronous reset while vector 5 is driven, then a fresh sweep.
        $display("[TB] test 5: reset mid-sweep");
        modelSigA = '0;
        for (int i = 0; i < 5; i++) begin
            pushA(3'(i));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (21) tick();
        checkOutput("A vec 5 before reset", 32'(dutInA), 32'(5));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("A async reset dut_in", 32'(dutInA), 32'(0));
        checkOutput("A async reset busy", 32'(busyA), 32'(0));
        checkOutput("A async reset done", 32'(doneA), 32'(0));
        checkOutput("A async reset signature", 32'(signatureA), 32'(0));
        checkOutput("A async reset sample_vec", 32'(sampleVecA), 32'(0));
        checkOutput("A async reset sample_data", 32'(sampleDataA), 32'(0));
        checkOutput("A async reset sample_valid", 32'(sampleValidA), 32'(0));
        checkOutput("A async reset wrap_cnt", 32'(wrapCntA), 32'(0));
        checkOutput("A pre-reset samples seen", 32'(expA.size()), 32'(0));
        tick();
        tick();
        checkOutput("A reset no done", 32'(doneA), 32'(0));
        rst_n = 1'b1;
        tick();
        sweepA(1'b0);
        checkOutput("A post-reset sig equals asc", 32'(signatureA), 32'(ascSig));

        // 6. Short instance: sample and advance share an edge.
        $display("[TB] test 6: N_IN=1 DWELL=2 SETTLE=1");
        modelSigB = '0;
        pushB(1'b0);
        pushB(1'b1);
        startB = 1'b1;
        tick();
        startB = 1'b0;
        checkOutput("B busy after start", 32'(busyB), 32'(1));
        checkOutput("B first vec", 32'(dutInB), 32'(0));
        tick();
        tick();
        checkOutput("B sample_valid coincident", 32'(sampleValidB), 32'(1));
        checkOutput("B sample uses old vec", 32'(sampleVecB), 32'(0));
        checkOutput("B vec advanced", 32'(dutInB), 32'(1));
        tick();
        checkOutput("B no done yet", 32'(doneB), 32'(0));
        tick();
        checkOutput("B done after 4", 32'(doneB), 32'(1));
        checkOutput("B busy at done", 32'(busyB), 32'(0));
        checkOutput("B dut_in holds", 32'(dutInB), 32'(1));
        tick();
        checkOutput("B done one cycle", 32'(doneB), 32'(0));
        checkOutput("B samples seen", 32'(expB.size()), 32'(0));
        checkOutput("B signature", 32'(signatureB), 32'(modelSigB));

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
